vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares one synchronous single-port video/data RAM between the VGA pixel fetcher and the DLX CPU data port.
//  VGA reads have fixed priority so scan-out is not disturbed; a starvation counter guarantees CPU forward progress.
//  Read data returns after a fixed RAM latency and is routed to its owner through an in-order tag pipeline.
//  Sits between the DLX core, the VGA controller and the RAM instance in DE1_Soc.
// PARAMETERS
//  ADDR_W    16  RAM word-address width
//  DATA_W    32  RAM data width
//  RD_LAT    1   RAM read latency in cycles (>=1); mem_rdata valid RD_LAT cycles after an accepted read
//  MAX_WAIT  8   consecutive denied CPU cycles before the CPU overrides VGA priority (>=1)
// PORTS
//  clock_50    in   1       system clock, all logic on rising edge
//  reset_n     in   1       asynchronous active-low reset
//  vga_req     in   1       VGA read request; addr held stable until acked
//  vga_addr    in   ADDR_W  VGA read address
//  vga_ack     out  1       VGA request accepted this cycle
//  vga_rvalid  out  1       vga_rdata valid
//  vga_rdata   out  DATA_W  VGA read data (= mem_rdata)
//  cpu_req     in   1       CPU request; we/addr/wdata held stable until acked
//  cpu_we      in   1       1 = write, 0 = read
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_ack     out  1       CPU request accepted this cycle
//  cpu_rvalid  out  1       cpu_rdata valid (reads only)
//  cpu_rdata   out  DATA_W  CPU read data (= mem_rdata)
//  mem_en      out  1       RAM access strobe
//  mem_we      out  1       RAM write enable
//  mem_addr    out  ADDR_W  RAM address
//  mem_wdata   out  DATA_W  RAM write data
//  mem_rdata   in   DATA_W  RAM read data
// BEHAVIOUR
//  - Reset (reset_n=0, async): tag pipe cleared to OWN_NONE, wait_cnt=0, vga_rvalid=cpu_rvalid=0;
//    acks, mem_en, mem_we forced 0 while reset_n=0. In-flight reads are discarded.
//  - Grant, combinational each cycle: cpu_req & wait_cnt==MAX_WAIT -> CPU; else vga_req -> VGA; else cpu_req -> CPU; else none.
//  - Winner: its ack=1, mem_en=1, mem_addr=its addr; mem_we=cpu_we & CPU won; mem_wdata=cpu_wdata.
//  - Transfer occurs at the rising edge where req&ack=1. Back-to-back requests allowed, one access/cycle max.
//  - wait_cnt: +1 per cycle with cpu_req=1 & cpu_ack=0, saturating at MAX_WAIT;
//    cleared on cpu_ack or cpu_req=0. Width $clog2(MAX_WAIT+1).
//  - Tag pipe: RD_LAT-deep shift register. Entry pushed each cycle: OWN_VGA / OWN_CPU for accepted reads, else OWN_NONE.
//    Writes push OWN_NONE.
//  - vga_rvalid / cpu_rvalid = (pipe output == owner), registered; exactly one rvalid per accepted read,
//    RD_LAT cycles after accept, in accept order. rdata muxes are pass-through of mem_rdata (no extra latency).
//  - Simultaneous: VGA read + CPU write same cycle -> one wins per rule above, loser keeps req.
//    CPU write never produces rvalid.
//  - vga_rvalid and cpu_rvalid are never both 1.
// STRUCTURE
//  - dlx_mem_pkg: typedef enum logic[1:0] owner_t {OWN_NONE, OWN_VGA, OWN_CPU};
//    MEM_ADDR_W/MEM_DATA_W defaults shared with VGA and CPU.
//  - Sub-module rd_tag_pipe #(RD_LAT): async-reset shift register of owner_t, push in / tag out.
//  - Top: grant logic, starvation counter, output muxes.
// TESTING
//  1. reset_n=0 with vga_req=cpu_req=1 -> vga_ack=cpu_ack=mem_en=0, rvalids 0.
//     Release -> vga_ack=1 in first cycle.
//  2. RD_LAT=1: vga_req, addr 0x0010, RAM returns 0x0000ABCD -> vga_ack that cycle,
//     next cycle vga_rvalid=1, vga_rdata=0x0000ABCD, cpu_rvalid=0.
//  3. MAX_WAIT=4, vga_req and cpu_req (read) held high -> vga_ack cycles 0-3, cpu_ack cycle 4,
//     vga_ack cycle 5, pattern repeats; wait_cnt back to 0 after cpu_ack.
//  4. CPU write addr 0x0003 data 0x00000055, no VGA -> mem_en=mem_we=1, mem_addr=0x0003,
//     mem_wdata=0x55; no rvalid afterwards.
//  5. RD_LAT=2, alternating accepted reads VGA/CPU/VGA over 3 cycles ->
//     rvalids vga,cpu,vga on cycles 2,3,4 with matching data.
//  6. VGA read accepted, reset_n pulsed low next cycle -> vga_rvalid never asserts for that read;
//     normal operation after release.

Source files
------------

// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the DLX memory subsystem: RAM geometry and the
// read-owner tag that travels alongside each in-flight RAM read.
package dlx_mem_pkg;

   localparam int MEM_ADDR_W = 16;
   localparam int MEM_DATA_W = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VGA  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// In-order owner tag pipeline: the tag pushed with an accepted read emerges
// RD_LAT cycles later, aligned with the RAM's read data.
module rd_tag_pipe
   import dlx_mem_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic   clk,
   input  logic   rst_n,
   input  owner_t i_push,
   output owner_t o_tag
);

   logic [RD_LAT-1:0][1:0] r_stage;

   generate
      if (RD_LAT == 1) begin : g_single
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_stage <= {RD_LAT{2'(OWN_NONE)}};
            end else begin
               r_stage <= 2'(i_push);
            end
         end
      end else begin : g_multi
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_stage <= {RD_LAT{2'(OWN_NONE)}};
            end else begin
               r_stage <= {r_stage[RD_LAT-2:0], 2'(i_push)};
            end
         end
      end
   endgenerate

   assign o_tag = owner_t'(r_stage[RD_LAT-1]);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port RAM arbiter between the VGA fetcher (priority) and the DLX data
// port, with a starvation override and tag-routed read returns.
module vram_arbiter
   import dlx_mem_pkg::*;
#(
   parameter int ADDR_W   = MEM_ADDR_W,
   parameter int DATA_W   = MEM_DATA_W,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 8
) (
   input  logic              clock_50,
   input  logic              reset_n,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_ack,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] r_waitCnt;
   logic              w_grantVga;
   logic              w_grantCpu;
   owner_t            w_push;
   owner_t            w_tag;

   // A CPU that has waited MAX_WAIT cycles jumps ahead of VGA for one access.
   always_comb begin
      w_grantVga = 1'b0;
      w_grantCpu = 1'b0;
      if (reset_n) begin
         if (cpu_req && (r_waitCnt == WAIT_TOP)) begin
            w_grantCpu = 1'b1;
         end else if (vga_req) begin
            w_grantVga = 1'b1;
         end else if (cpu_req) begin
            w_grantCpu = 1'b1;
         end
      end
   end

   assign vga_ack   = w_grantVga;
   assign cpu_ack   = w_grantCpu;
   assign mem_en    = w_grantVga | w_grantCpu;
   assign mem_we    = w_grantCpu & cpu_we;
   assign mem_addr  = w_grantCpu ? cpu_addr : vga_addr;
   assign mem_wdata = cpu_wdata;

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_waitCnt <= '0;
      end else if (cpu_req && !w_grantCpu) begin
         if (r_waitCnt != WAIT_TOP) begin
            r_waitCnt <= r_waitCnt + 1'b1;
         end
      end else begin
         r_waitCnt <= '0;
      end
   end

   // Writes and idle cycles push OWN_NONE so the pipe stays cycle-aligned.
   always_comb begin
      w_push = OWN_NONE;
      if (w_grantVga) begin
         w_push = OWN_VGA;
      end else if (w_grantCpu && !cpu_we) begin
         w_push = OWN_CPU;
      end
   end

   rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tagPipe (
      .clk    (clock_50),
      .rst_n  (reset_n),
      .i_push (w_push),
      .o_tag  (w_tag)
   );

   assign vga_rvalid = (w_tag == OWN_VGA);
   assign cpu_rvalid = (w_tag == OWN_CPU);
   assign vga_rdata  = mem_rdata;
   assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: two instances (read latency 1 and 2, starvation
// limit 4) share stimulus; each owns a small RAM model.
module tb_vram_arbiter;

   localparam int MAX_WAIT = 4;
   localparam int LAT_A    = 1;
   localparam int LAT_B    = 2;

   logic        clock50 = 1'b0;
   logic        resetN;
   logic        ramInit;
   logic        vgaReq, cpuReq, cpuWe;
   logic [15:0] vgaAddr, cpuAddr;
   logic [31:0] cpuWdata;

   logic        vgaAckA, vgaRvalidA, cpuAckA, cpuRvalidA, memEnA, memWeA;
   logic [15:0] memAddrA;
   logic [31:0] vgaRdataA, cpuRdataA, memWdataA, memRdataA;
   logic        vgaAckB, vgaRvalidB, cpuAckB, cpuRvalidB, memEnB, memWeB;
   logic [15:0] memAddrB;
   logic [31:0] vgaRdataB, cpuRdataB, memWdataB, memRdataB;

   logic [31:0] ramA [256];
   logic [31:0] ramB [256];
   logic [31:0] rdA1, rdB1, rdB2;

   typedef struct {
      int          own;
      logic [31:0] data;
      int          due;
   } rdEntry_t;

   rdEntry_t    qA[$];
   rdEntry_t    qB[$];
   logic [31:0] modelMem [256];
   int          denyCnt, cyc, nCompared, nMismatched;
   logic        expVga, expCpu, expEn, expWe;
   logic [15:0] expAddr;
   logic [1:0]  expRvA, expRvB;
   logic [31:0] expDataA, expDataB;

   always #5 clock50 = ~clock50;

   vram_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(LAT_A), .MAX_WAIT(MAX_WAIT)) dutA (
      .clock_50(clock50), .reset_n(resetN),
      .vga_req(vgaReq), .vga_addr(vgaAddr), .vga_ack(vgaAckA),
      .vga_rvalid(vgaRvalidA), .vga_rdata(vgaRdataA),
      .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
      .cpu_ack(cpuAckA), .cpu_rvalid(cpuRvalidA), .cpu_rdata(cpuRdataA),
      .mem_en(memEnA), .mem_we(memWeA), .mem_addr(memAddrA),
      .mem_wdata(memWdataA), .mem_rdata(memRdataA)
   );

   vram_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(LAT_B), .MAX_WAIT(MAX_WAIT)) dutB (
      .clock_50(clock50), .reset_n(resetN),
      .vga_req(vgaReq), .vga_addr(vgaAddr), .vga_ack(vgaAckB),
      .vga_rvalid(vgaRvalidB), .vga_rdata(vgaRdataB),
      .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
      .cpu_ack(cpuAckB), .cpu_rvalid(cpuRvalidB), .cpu_rdata(cpuRdataB),
      .mem_en(memEnB), .mem_we(memWeB), .mem_addr(memAddrB),
      .mem_wdata(memWdataB), .mem_rdata(memRdataB)
   );

   function automatic logic [31:0] ramDefault(input logic [7:0] a);
      if (a == 8'h10) return 32'h0000ABCD;
      return {8'hA5, a, ~a, 8'h3C};
   endfunction

   // RAM models: capture every cycle, data is only meaningful for reads
   always @(posedge clock50) begin
      if (ramInit) begin
         for (int i = 0; i < 256; i++) ramA[8'(i)] <= ramDefault(8'(i));
      end else if (memEnA && memWeA) begin
         ramA[memAddrA[7:0]] <= memWdataA;
      end
      rdA1 <= ramA[memAddrA[7:0]];
   end

   always @(posedge clock50) begin
      if (ramInit) begin
         for (int i = 0; i < 256; i++) ramB[8'(i)] <= ramDefault(8'(i));
      end else if (memEnB && memWeB) begin
         ramB[memAddrB[7:0]] <= memWdataB;
      end
      rdB1 <= ramB[memAddrB[7:0]];
      rdB2 <= rdB1;
   end

   assign memRdataA = rdA1;
   assign memRdataB = rdB2;

   // Reference model: expected grant and read returns for the current inputs
   task automatic computeExpect();
      if (!resetN) begin
         qA.delete();
         qB.delete();
         denyCnt = 0;
      end
      expVga = 1'b0;
      expCpu = 1'b0;
      if (resetN) begin
         if (cpuReq && denyCnt >= MAX_WAIT) expCpu = 1'b1;
         else if (vgaReq) expVga = 1'b1;
         else if (cpuReq) expCpu = 1'b1;
      end
      expEn   = expVga | expCpu;
      expWe   = expCpu & cpuWe;
      expAddr = expCpu ? cpuAddr : vgaAddr;
      expRvA = 2'b00;
      expDataA = '0;
      if (qA.size() > 0 && qA[0].due == cyc) begin
         expRvA   = (qA[0].own == 1) ? 2'b10 : 2'b01;
         expDataA = qA[0].data;
      end
      expRvB = 2'b00;
      expDataB = '0;
      if (qB.size() > 0 && qB[0].due == cyc) begin
         expRvB   = (qB[0].own == 1) ? 2'b10 : 2'b01;
         expDataB = qB[0].data;
      end
   endtask

   task automatic advance();
      rdEntry_t e;
      @(posedge clock50);
      if (resetN) begin
         if (qA.size() > 0 && qA[0].due == cyc) qA.delete(0);
         if (qB.size() > 0 && qB[0].due == cyc) qB.delete(0);
         if (expVga || (expCpu && !cpuWe)) begin
            e.own  = expVga ? 1 : 2;
            e.data = modelMem[expAddr[7:0]];
            e.due  = cyc + LAT_A;
            qA.push_back(e);
            e.due  = cyc + LAT_B;
            qB.push_back(e);
         end else if (expCpu) begin
            modelMem[cpuAddr[7:0]] = cpuWdata;
         end
         denyCnt = (cpuReq && !expCpu) ? denyCnt + 1 : 0;
      end
      cyc++;
      @(negedge clock50);
   endtask

   task automatic drive(input logic rst, input logic vr, input logic [15:0] va,
                        input logic cr, input logic cw, input logic [15:0] ca,
                        input logic [31:0] cd);
      resetN   = rst;
      vgaReq   = vr;
      vgaAddr  = va;
      cpuReq   = cr;
      cpuWe    = cw;
      cpuAddr  = ca;
      cpuWdata = cd;
      #1;
      computeExpect();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
         advance();
      end
   endtask

   task automatic test_reset();
      @(negedge clock50);
      ramInit = 1'b0;
      drive(1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0021, 32'h0);
      nCompared++;
      if ({vgaAckA, cpuAckA, memEnA, memWeA, vgaRvalidA, cpuRvalidA} !== 6'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_outputs_a got=%b want=000000", {vgaAckA, cpuAckA, memEnA, memWeA, vgaRvalidA, cpuRvalidA});
      end
      nCompared++;
      if ({vgaAckB, cpuAckB, memEnB, memWeB, vgaRvalidB, cpuRvalidB} !== 6'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_outputs_b got=%b want=000000", {vgaAckB, cpuAckB, memEnB, memWeB, vgaRvalidB, cpuRvalidB});
      end
      advance();
      drive(1'b1, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0021, 32'h0);
      nCompared++;
      if ({vgaAckA, cpuAckA, vgaAckB, cpuAckB} !== 4'b1010) begin
         nMismatched++;
         $display("[TB] FAIL release_first_grant got=%b want=1010", {vgaAckA, cpuAckA, vgaAckB, cpuAckB});
      end
      advance();
      idle(3);
   endtask

   task automatic test_vga_read();
      drive(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0);
      nCompared++;
      if ({vgaAckA, memEnA, memWeA, memAddrA} !== {3'b110, 16'h0010}) begin
         nMismatched++;
         $display("[TB] FAIL vga_read_accept got=%h want=%h", {vgaAckA, memEnA, memWeA, memAddrA}, {3'b110, 16'h0010});
      end
      advance();
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
      nCompared++;
      if ({vgaRvalidA, cpuRvalidA, vgaRdataA, vgaRvalidB, cpuRvalidB} !== {2'b10, 32'h0000ABCD, 2'b00}) begin
         nMismatched++;
         $display("[TB] FAIL vga_read_lat1 got=%h want=%h", {vgaRvalidA, cpuRvalidA, vgaRdataA, vgaRvalidB, cpuRvalidB}, {2'b10, 32'h0000ABCD, 2'b00});
      end
      advance();
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
      nCompared++;
      if ({vgaRvalidB, cpuRvalidB, vgaRdataB, vgaRvalidA, cpuRvalidA} !== {2'b10, 32'h0000ABCD, 2'b00}) begin
         nMismatched++;
         $display("[TB] FAIL vga_read_lat2 got=%h want=%h", {vgaRvalidB, cpuRvalidB, vgaRdataB, vgaRvalidA, cpuRvalidA}, {2'b10, 32'h0000ABCD, 2'b00});
      end
      advance();
   endtask

   task automatic test_starvation();
      logic [1:0] want;
      for (int k = 0; k < 12; k++) begin
         drive(1'b1, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0005, 32'h0);
         want = (k % 5 == 4) ? 2'b01 : 2'b10;
         nCompared++;
         if ({vgaAckA, cpuAckA} !== want || {vgaAckB, cpuAckB} !== want) begin
            nMismatched++;
            $display("[TB] FAIL starvation k=%0d got a=%b b=%b want=%b", k, {vgaAckA, cpuAckA}, {vgaAckB, cpuAckB}, want);
         end
         advance();
      end
      idle(3);
   endtask

   task automatic test_cpu_write();
      drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0003, 32'h00000055);
      nCompared++;
      if ({cpuAckA, vgaAckA, memEnA, memWeA, memAddrA, memWdataA} !== {4'b1011, 16'h0003, 32'h00000055}) begin
         nMismatched++;
         $display("[TB] FAIL cpu_write_a got=%h want=%h", {cpuAckA, vgaAckA, memEnA, memWeA, memAddrA, memWdataA}, {4'b1011, 16'h0003, 32'h00000055});
      end
      nCompared++;
      if ({cpuAckB, vgaAckB, memEnB, memWeB, memAddrB, memWdataB} !== {4'b1011, 16'h0003, 32'h00000055}) begin
         nMismatched++;
         $display("[TB] FAIL cpu_write_b got=%h want=%h", {cpuAckB, vgaAckB, memEnB, memWeB, memAddrB, memWdataB}, {4'b1011, 16'h0003, 32'h00000055});
      end
      advance();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
         nCompared++;
         if ({vgaRvalidA, cpuRvalidA, vgaRvalidB, cpuRvalidB} !== 4'b0) begin
            nMismatched++;
            $display("[TB] FAIL cpu_write_no_rvalid k=%0d got=%b want=0000", k, {vgaRvalidA, cpuRvalidA, vgaRvalidB, cpuRvalidB});
         end
         advance();
      end
   endtask

   task automatic test_interleave();
      logic [31:0] seqData [3];
      logic [1:0]  wantA, wantB;
      logic [31:0] gotData;
      seqData[0] = 32'h0000ABCD;
      seqData[1] = 32'h00000055;
      seqData[2] = ramDefault(8'h11);
      for (int k = 0; k < 6; k++) begin
         case (k)
            0:       drive(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0);
            1:       drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0003, 32'h0);
            2:       drive(1'b1, 1'b1, 16'h0011, 1'b0, 1'b0, 16'h0, 32'h0);
            default: drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
         endcase
         wantA = (k == 1 || k == 3) ? 2'b10 : (k == 2) ? 2'b01 : 2'b00;
         wantB = (k == 2 || k == 4) ? 2'b10 : (k == 3) ? 2'b01 : 2'b00;
         nCompared++;
         if ({vgaRvalidA, cpuRvalidA} !== wantA || {vgaRvalidB, cpuRvalidB} !== wantB) begin
            nMismatched++;
            $display("[TB] FAIL interleave_rvalid k=%0d got a=%b b=%b want a=%b b=%b", k, {vgaRvalidA, cpuRvalidA}, {vgaRvalidB, cpuRvalidB}, wantA, wantB);
         end
         if (k >= 2 && k <= 4) begin
            gotData = (k == 3) ? cpuRdataB : vgaRdataB;
            nCompared++;
            if (gotData !== seqData[k-2]) begin
               nMismatched++;
               $display("[TB] FAIL interleave_data k=%0d got=%h want=%h", k, gotData, seqData[k-2]);
            end
         end
         advance();
      end
   endtask

   task automatic test_reset_flush();
      drive(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0);
      nCompared++;
      if (vgaAckA !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL flush_accept got=%b want=1", vgaAckA);
      end
      advance();
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
      nCompared++;
      if ({vgaRvalidA, vgaRvalidB} !== 2'b00) begin
         nMismatched++;
         $display("[TB] FAIL flush_in_reset got=%b want=00", {vgaRvalidA, vgaRvalidB});
      end
      advance();
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
      nCompared++;
      if ({vgaRvalidA, cpuRvalidA, vgaRvalidB, cpuRvalidB} !== 4'b0) begin
         nMismatched++;
         $display("[TB] FAIL flush_after_release got=%b want=0000", {vgaRvalidA, cpuRvalidA, vgaRvalidB, cpuRvalidB});
      end
      advance();
      drive(1'b1, 1'b1, 16'h0012, 1'b0, 1'b0, 16'h0, 32'h0);
      advance();
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
      nCompared++;
      if ({vgaRvalidA, vgaRdataA} !== {1'b1, ramDefault(8'h12)}) begin
         nMismatched++;
         $display("[TB] FAIL flush_resume_a got=%h want=%h", {vgaRvalidA, vgaRdataA}, {1'b1, ramDefault(8'h12)});
      end
      advance();
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
      nCompared++;
      if ({vgaRvalidB, vgaRdataB} !== {1'b1, ramDefault(8'h12)}) begin
         nMismatched++;
         $display("[TB] FAIL flush_resume_b got=%h want=%h", {vgaRvalidB, vgaRdataB}, {1'b1, ramDefault(8'h12)});
      end
      advance();
   endtask

   task automatic test_random();
      logic        vr, cr, cw;
      logic [15:0] va, ca;
      logic [31:0] cd, got;
      vr = 1'b0; cr = 1'b0; cw = 1'b0; va = '0; ca = '0; cd = '0;
      for (int n = 0; n < 400; n++) begin
         if (!vr || expVga) begin
            vr = ($urandom_range(0, 9) < 7);
            va = 16'($urandom_range(0, 31));
         end
         if (!cr || expCpu) begin
            cr = ($urandom_range(0, 9) < 6);
            cw = 1'($urandom_range(0, 1));
            ca = 16'($urandom_range(0, 31));
            cd = $urandom;
         end
         drive(1'b1, vr, va, cr, cw, ca, cd);
         nCompared++;
         if ({vgaAckA, cpuAckA, memEnA, memWeA} !== {expVga, expCpu, expEn, expWe} ||
             {vgaAckB, cpuAckB, memEnB, memWeB} !== {expVga, expCpu, expEn, expWe}) begin
            nMismatched++;
            $display("[TB] FAIL rand_grant n=%0d got a=%b b=%b want=%b", n, {vgaAckA, cpuAckA, memEnA, memWeA}, {vgaAckB, cpuAckB, memEnB, memWeB}, {expVga, expCpu, expEn, expWe});
         end
         if (expEn) begin
            nCompared++;
            if (memAddrA !== expAddr || memAddrB !== expAddr) begin
               nMismatched++;
               $display("[TB] FAIL rand_addr n=%0d got a=%h b=%h want=%h", n, memAddrA, memAddrB, expAddr);
            end
         end
         if (expWe) begin
            nCompared++;
            if (memWdataA !== cd || memWdataB !== cd) begin
               nMismatched++;
               $display("[TB] FAIL rand_wdata n=%0d got a=%h b=%h want=%h", n, memWdataA, memWdataB, cd);
            end
         end
         nCompared++;
         if ({vgaRvalidA, cpuRvalidA} !== expRvA || {vgaRvalidB, cpuRvalidB} !== expRvB) begin
            nMismatched++;
            $display("[TB] FAIL rand_rvalid n=%0d got a=%b b=%b want a=%b b=%b", n, {vgaRvalidA, cpuRvalidA}, {vgaRvalidB, cpuRvalidB}, expRvA, expRvB);
         end
         if (expRvA != 2'b00) begin
            got = expRvA[1] ? vgaRdataA : cpuRdataA;
            nCompared++;
            if (got !== expDataA) begin
               nMismatched++;
               $display("[TB] FAIL rand_rdata_a n=%0d got=%h want=%h", n, got, expDataA);
            end
         end
         if (expRvB != 2'b00) begin
            got = expRvB[1] ? vgaRdataB : cpuRdataB;
            nCompared++;
            if (got !== expDataB) begin
               nMismatched++;
               $display("[TB] FAIL rand_rdata_b n=%0d got=%h want=%h", n, got, expDataB);
            end
         end
         advance();
      end
      idle(3);
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      cyc         = 0;
      denyCnt     = 0;
      ramInit     = 1'b1;
      resetN      = 1'b0;
      vgaReq      = 1'b0;
      cpuReq      = 1'b0;
      cpuWe       = 1'b0;
      vgaAddr     = '0;
      cpuAddr     = '0;
      cpuWdata    = '0;
      expVga      = 1'b0;
      expCpu      = 1'b0;
      for (int i = 0; i < 256; i++) modelMem[8'(i)] = ramDefault(8'(i));
      test_reset();
      test_vga_read();
      test_starvation();
      test_cpu_write();
      test_interleave();
      test_reset_flush();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

endmodule
